// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Purpose  : Shares one SDRAM controller command port between the video line
//            reader (priority) and the frame-buffer writer. Define
//            SDRAM_ARB_FAIRNESS_EN to bound writer starvation.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
  parameter int AW       = 22,
  parameter int LW       = 9,
  parameter int FAIR_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sdr_init_done,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  input  logic [LW-1:0] vid_len,
  output logic          vid_gnt,
  output logic [15:0]   vid_rdata,
  output logic          vid_rvalid,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [LW-1:0] wr_len,
  output logic          wr_gnt,
  input  logic [15:0]   wr_data,
  output logic          wr_dreq,
  output logic          ctl_cmd_valid,
  input  logic          ctl_cmd_ready,
  output logic          ctl_cmd_we,
  output logic [AW-1:0] ctl_cmd_addr,
  output logic [LW-1:0] ctl_cmd_len,
  input  logic          ctl_wdata_req,
  output logic [15:0]   ctl_wdata,
  input  logic          ctl_rvalid,
  input  logic [15:0]   ctl_rdata,
  input  logic          ctl_done,
  output logic          busy,
  output logic          err_len
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_XFER  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [LW-1:0] c_MAX_LEN = {1'b1, {(LW-1){1'b0}}};

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_len, r_cnt, w_cnt_next, w_sel_len;
  logic          r_we, r_vid_rvalid, r_err;
  logic [15:0]   r_vid_rdata;
  logic          w_sel_vid, w_sel_wr, w_grant, w_len_bad, w_fair_force;
  logic          w_in_xfer, w_vid_beat, w_wr_beat, w_stray, w_cnt_err;

  assign w_in_xfer  = (r_state == S_XFER);
  assign w_vid_beat = w_in_xfer && !r_we && ctl_rvalid;
  assign w_wr_beat  = w_in_xfer && r_we && ctl_wdata_req;
  assign w_stray    = !w_in_xfer && (ctl_rvalid || ctl_wdata_req);
  assign w_cnt_next = r_cnt + {{(LW-1){1'b0}}, (w_vid_beat || w_wr_beat)};
  assign w_cnt_err  = w_in_xfer && ctl_done && (w_cnt_next != r_len);

  // Owner selection; reset masks the combinational grant so outputs stay 0.
  always_comb begin
    w_sel_vid = 1'b0;
    w_sel_wr  = 1'b0;
    if (r_state == S_IDLE && sdr_init_done && !reset) begin
      if (vid_req && !(wr_req && w_fair_force)) w_sel_vid = 1'b1;
      else if (wr_req)                          w_sel_wr  = 1'b1;
    end
  end

  assign w_grant   = w_sel_vid || w_sel_wr;
  assign w_sel_len = w_sel_wr ? wr_len : vid_len;
  assign w_len_bad = (w_sel_len == '0) || (w_sel_len > c_MAX_LEN);

`ifdef SDRAM_ARB_FAIRNESS_EN
  logic [2:0] r_fair_cnt;

  assign w_fair_force = (r_fair_cnt == 3'(FAIR_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fair_cnt <= 3'd0;
    end else if (r_state == S_IDLE) begin
      if (w_sel_wr || !wr_req) r_fair_cnt <= 3'd0;
      else if (w_sel_vid)      r_fair_cnt <= r_fair_cnt + 3'd1;
    end
  end
`else
  // Strict video priority; FAIR_MAX has no effect in this build.
  assign w_fair_force = (FAIR_MAX < 0);
`endif

  always_comb begin
    w_state_next  = r_state;
    vid_gnt       = w_sel_vid;
    wr_gnt        = w_sel_wr;
    ctl_cmd_valid = (r_state == S_ISSUE);
    wr_dreq       = w_wr_beat;
    ctl_wdata     = (w_in_xfer && r_we) ? wr_data : 16'h0000;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (w_grant) w_state_next = w_len_bad ? S_GAP : S_ISSUE;
      S_ISSUE: if (ctl_cmd_ready) w_state_next = S_XFER;
      S_XFER:  if (ctl_done) w_state_next = S_GAP;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_len        <= '0;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_vid_rvalid <= 1'b0;
      r_vid_rdata  <= 16'h0000;
      r_err        <= 1'b0;
    end else begin
      r_vid_rvalid <= w_vid_beat;
      if (w_vid_beat) r_vid_rdata <= ctl_rdata;
      if (w_grant) begin
        r_addr <= w_sel_wr ? wr_addr : vid_addr;
        r_len  <= w_sel_len;
        r_we   <= w_sel_wr;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= w_cnt_next;
      end
      if ((w_grant && w_len_bad) || w_cnt_err || w_stray) r_err <= 1'b1;
    end
  end

  assign ctl_cmd_we   = r_we;
  assign ctl_cmd_addr = r_addr;
  assign ctl_cmd_len  = r_len;
  assign vid_rvalid   = r_vid_rvalid;
  assign vid_rdata    = r_vid_rdata;
  assign err_len      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Purpose  : Self-checking bench for sdram_port_arbiter with a behavioural
//            controller/requester model and randomized bursts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

  localparam int AW       = 22;
  localparam int LW       = 9;
  localparam int FAIR_MAX = 4;

  logic          clk = 1'b0;
  logic          reset, sdr_init_done;
  logic          vid_req, wr_req, vid_gnt, wr_gnt;
  logic [AW-1:0] vid_addr, wr_addr, ctl_cmd_addr;
  logic [LW-1:0] vid_len, wr_len, ctl_cmd_len;
  logic [15:0]   vid_rdata, wr_data, ctl_wdata, ctl_rdata;
  logic          vid_rvalid, wr_dreq;
  logic          ctl_cmd_valid, ctl_cmd_ready, ctl_cmd_we;
  logic          ctl_wdata_req, ctl_rvalid, ctl_done, busy, err_len;

  int n_checks = 0;
  int n_errors = 0;
  bit err_exp  = 1'b0;

  sdram_port_arbiter #(.AW(AW), .LW(LW), .FAIR_MAX(FAIR_MAX)) dut (
    .clk(clk), .reset(reset), .sdr_init_done(sdr_init_done),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_len(vid_len), .vid_gnt(vid_gnt),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
    .wr_data(wr_data), .wr_dreq(wr_dreq),
    .ctl_cmd_valid(ctl_cmd_valid), .ctl_cmd_ready(ctl_cmd_ready), .ctl_cmd_we(ctl_cmd_we),
    .ctl_cmd_addr(ctl_cmd_addr), .ctl_cmd_len(ctl_cmd_len),
    .ctl_wdata_req(ctl_wdata_req), .ctl_wdata(ctl_wdata),
    .ctl_rvalid(ctl_rvalid), .ctl_rdata(ctl_rdata), .ctl_done(ctl_done),
    .busy(busy), .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant k (0-based) under continuous contention: writer every FAIR_MAX+1.
  function automatic bit fair_expect_wr(input int k);
`ifdef SDRAM_ARB_FAIRNESS_EN
    return (k % (FAIR_MAX + 1)) == FAIR_MAX;
`else
    return (k < 0);
`endif
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    vid_req = 1'b0; wr_req = 1'b0; ctl_cmd_ready = 1'b0;
    ctl_wdata_req = 1'b0; ctl_rvalid = 1'b0; ctl_done = 1'b0;
    err_exp = 1'b0;
    step();
    #3;
    chk("rst_flags", 32'({vid_gnt, wr_gnt, vid_rvalid, wr_dreq, ctl_cmd_valid,
                          ctl_cmd_we, busy, err_len}), 32'd0);
    chk("rst_addr", 32'(ctl_cmd_addr), 32'd0);
    chk("rst_len", 32'(ctl_cmd_len), 32'd0);
    chk("rst_data", 32'({vid_rdata, ctl_wdata}), 32'd0);
    reset = 1'b0;
    step();
  endtask

  // Waits for a grant, plays controller and requester for one burst, and
  // returns at the start of the IDLE cycle after GAP.
  task automatic do_burst(input bit exp_wr, input bit hold, input int rdy_dly,
                          input int nbeats, input bit idx_data);
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_len;
    logic [15:0]   d, prev_d;
    bit            bad, beat, prev_v;
    int            waited, gap;
    waited = 0;
    #3;
    while (!(vid_gnt || wr_gnt) && waited < 8) begin
      step(); #3; waited++;
    end
    chk("gnt_seen", 32'(vid_gnt | wr_gnt), 32'd1);
    if (!(vid_gnt || wr_gnt)) return;
    chk("gnt_wr", 32'(wr_gnt), 32'(exp_wr));
    chk("gnt_vid", 32'(vid_gnt), 32'(!exp_wr));
    chk("busy_at_gnt", 32'(busy), 32'd0);
    e_addr = exp_wr ? wr_addr : vid_addr;
    e_len  = exp_wr ? wr_len : vid_len;
    bad    = (e_len == '0) || (int'(e_len) > 256);
    step();
    if (!hold) begin
      if (exp_wr) begin wr_req = 1'b0; wr_addr = 22'($urandom); wr_len = 9'($urandom); end
      else        begin vid_req = 1'b0; vid_addr = 22'($urandom); vid_len = 9'($urandom); end
    end
    if (bad) begin
      err_exp = 1'b1;
      #3;
      chk("bad_no_cmd", 32'(ctl_cmd_valid), 32'd0);
      chk("bad_busy", 32'(busy), 32'd1);
      chk("bad_err", 32'(err_len), 32'd1);
      step();
      return;
    end
    for (int k = 0; k <= rdy_dly; k++) begin
      ctl_cmd_ready = (k == rdy_dly);
      #3;
      chk("cmd_valid", 32'(ctl_cmd_valid), 32'd1);
      chk("cmd_we", 32'(ctl_cmd_we), 32'(exp_wr));
      chk("cmd_addr", 32'(ctl_cmd_addr), 32'(e_addr));
      chk("cmd_len", 32'(ctl_cmd_len), 32'(e_len));
      step();
    end
    ctl_cmd_ready = 1'b0;
    prev_v = 1'b0;
    prev_d = 16'h0000;
    for (int i = 0; i < nbeats; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g <= gap; g++) begin
        beat = (g == gap);
        d = idx_data ? 16'(i) : 16'($urandom);
        if (exp_wr) begin ctl_wdata_req = beat; wr_data = d; end
        else        begin ctl_rvalid = beat; ctl_rdata = d; end
        #3;
        if (exp_wr) begin
          chk("wr_dreq", 32'(wr_dreq), 32'(beat));
          if (beat) chk("wr_data", 32'(ctl_wdata), 32'(d));
        end else begin
          chk("vid_rvalid", 32'(vid_rvalid), 32'(prev_v));
          if (prev_v) chk("vid_rdata", 32'(vid_rdata), 32'(prev_d));
        end
        step();
        prev_v = beat;
        prev_d = d;
      end
    end
    ctl_wdata_req = 1'b0; ctl_rvalid = 1'b0; ctl_done = 1'b1;
    #3;
    if (!exp_wr) begin
      chk("vid_rvalid_last", 32'(vid_rvalid), 32'(prev_v));
      if (prev_v) chk("vid_rdata_last", 32'(vid_rdata), 32'(prev_d));
    end
    step();
    ctl_done = 1'b0;
    if (nbeats != int'(e_len)) err_exp = 1'b1;
    #3;
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_cmd", 32'(ctl_cmd_valid), 32'd0);
    chk("gap_rvalid", 32'(vid_rvalid), 32'd0);
    chk("err_len", 32'(err_len), 32'(err_exp));
    step();
  endtask

  initial begin
    int bad_cycles, len;
    bit owner;
    reset = 1'b1; sdr_init_done = 1'b0;
    vid_req = 1'b0; wr_req = 1'b0; vid_addr = '0; wr_addr = '0; vid_len = '0; wr_len = '0;
    wr_data = 16'h0; ctl_cmd_ready = 1'b0; ctl_wdata_req = 1'b0; ctl_rvalid = 1'b0;
    ctl_rdata = 16'h0; ctl_done = 1'b0;
    apply_reset();

    // Init gating, then the 256-beat video read.
    vid_req = 1'b1; vid_addr = 22'(4096 * 5); vid_len = 9'd256;
    bad_cycles = 0;
    for (int c = 0; c < 100; c++) begin
      #3;
      if (vid_gnt || ctl_cmd_valid) bad_cycles++;
      step();
    end
    chk("init_gate", 32'(bad_cycles), 32'd0);
    sdr_init_done = 1'b1;
    #3;
    chk("init_gnt", 32'(vid_gnt), 32'd1);
    do_burst(1'b0, 1'b0, 0, 256, 1'b1);

    // Write routing with a stalled command handshake.
    wr_req = 1'b1; wr_addr = 22'h1000; wr_len = 9'd8;
    do_burst(1'b1, 1'b0, 3, 8, 1'b0);

    // Randomized single-requester bursts.
    for (int n = 0; n < 16; n++) begin
      owner = 1'($urandom_range(0, 1));
      len   = $urandom_range(1, 12);
      if (owner) begin wr_req = 1'b1; wr_addr = 22'($urandom); wr_len = 9'(len); end
      else       begin vid_req = 1'b1; vid_addr = 22'($urandom); vid_len = 9'(len); end
      do_burst(owner, 1'b0, $urandom_range(0, 3), len, 1'b0);
      for (int s = 0; s < $urandom_range(0, 2); s++) step();
    end

    // Continuous contention: grant order.
    vid_req = 1'b1; wr_req = 1'b1;
    vid_addr = 22'($urandom); wr_addr = 22'($urandom);
    vid_len = 9'd2; wr_len = 9'd2;
    for (int k = 0; k < 10; k++) do_burst(fair_expect_wr(k), 1'b1, 0, 2, 1'b0);
    vid_req = 1'b0; wr_req = 1'b0;
    step();

    // Length errors.
    apply_reset();
    wr_req = 1'b1; wr_len = 9'd0;
    do_burst(1'b1, 1'b0, 0, 0, 1'b0);
    apply_reset();
    vid_req = 1'b1; vid_len = 9'($urandom_range(257, 511));
    do_burst(1'b0, 1'b0, 0, 0, 1'b0);
    apply_reset();
    vid_req = 1'b1; vid_len = 9'd16;
    do_burst(1'b0, 1'b0, 1, 15, 1'b0);

    // Stray read beat in IDLE.
    apply_reset();
    ctl_rvalid = 1'b1;
    step();
    ctl_rvalid = 1'b0;
    #3;
    chk("stray_rvalid", 32'(vid_rvalid), 32'd0);
    chk("stray_err", 32'(err_len), 32'd1);
    step();

    // Reset mid-XFER after 10 of 64 beats, then a normal request.
    apply_reset();
    vid_req = 1'b1; vid_addr = 22'($urandom); vid_len = 9'd64;
    #3;
    chk("mid_gnt", 32'(vid_gnt), 32'd1);
    step();
    vid_req = 1'b0;
    #3;
    chk("mid_cmd", 32'(ctl_cmd_valid), 32'd1);
    ctl_cmd_ready = 1'b1;
    step();
    ctl_cmd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ctl_rvalid = 1'b1; ctl_rdata = 16'(i);
      step();
    end
    apply_reset();
    wr_req = 1'b1; wr_addr = 22'($urandom); wr_len = 9'd4;
    do_burst(1'b1, 1'b0, 1, 4, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
